// File: rtl/wam_pkg.sv
// Shared definitions for the multi-hole whack-a-mole core: game state
// encodings, LFSR constants and the index-to-one-hot helper.
package wam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_UP    = 3'd2,
    ST_GAP   = 3'd3,
    ST_END   = 3'd4
  } state_t;

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps at positions 16,14,13,11 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int MAX_HOLES = 16;
  localparam int MAX_IDX_W = 4;

  function automatic logic [MAX_HOLES-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
    return {{(MAX_HOLES-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/wam_debouncer.sv
// One button channel: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on each accepted rising edge. A button that is
// already held when reset is released never produces a press until it
// has been seen released.
module wam_debouncer #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int               CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_p0, sync_p1;
  logic             arm_p0, arm_p1;
  logic             level;
  logic             blocked;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser for the asynchronous raw button
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Marks when the synchroniser holds real input samples after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_p0 <= 1'b0;
      arm_p1 <= 1'b0;
    end else begin
      arm_p0 <= 1'b1;
      arm_p1 <= arm_p0;
    end
  end

  // Stability counter, debounced level and press pulse generation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level   <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
      blocked <= 1'b1;
    end else begin
      press <= 1'b0;
      if (arm_p1 && !sync_p1) blocked <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_p1;
        press <= sync_p1 & ~blocked;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/whack_a_mole_multi.sv
// Multi-hole whack-a-mole game core: per-button debouncing, LFSR mole
// placement, programmable up/gap timers, saturating score, lives and
// one-cycle hit/miss pulses.
module whack_a_mole_multi
  import wam_pkg::*;
#(
  parameter int NUM_HOLES   = 4,
  parameter int SCORE_W     = 8,
  parameter int LIVES_W     = 4,
  parameter int LIVES_INIT  = 3,
  parameter int DEB_CYCLES  = 1000000,
  parameter int MOLE_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 10000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] buttons,
  output logic [NUM_HOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [LIVES_W-1:0]   lives,
  output logic [2:0]           state,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);

  localparam int IDX_W   = $clog2(NUM_HOLES);
  localparam int TMR_MAX = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]   MOLE_LOAD  = TMR_W'(MOLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);

  state_t               st;
  logic [NUM_HOLES-1:0] press;
  logic [LFSR_W-1:0]    lfsr;
  logic [TMR_W-1:0]     timer;
  logic [IDX_W-1:0]     prev_idx;
  logic                 prev_vld;
  logic                 start_q;
  logic                 start_rise;
  logic                 wrong;
  logic                 correct;
  logic                 last_life;
  logic [IDX_W-1:0]     rand_idx;
  logic [IDX_W-1:0]     spawn_idx;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
  endfunction

  function automatic logic [LIVES_W-1:0] sat_dec(input logic [LIVES_W-1:0] v);
    return (v == '0) ? v : v - LIVES_W'(1);
  endfunction

  for (genvar i = 0; i < NUM_HOLES; i++) begin : g_deb
    wam_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (buttons[i]),
      .press (press[i])
    );
  end

  assign start_rise = start & ~start_q;
  assign wrong      = |(press & ~mole);
  assign correct    = |(press & mole);
  assign last_life  = (lives == LIVES_W'(1));
  assign rand_idx   = lfsr[IDX_W-1:0];
  // Never show the same hole twice in a row
  assign spawn_idx  = (prev_vld && (rand_idx == prev_idx)) ? rand_idx + IDX_W'(1) : rand_idx;
  assign state      = st;

  // Free-running placement LFSR, also advancing while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
  end

  // Start level history for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) start_q <= 1'b0;
    else       start_q <= start;
  end

  // Game FSM with registered mole, score, lives, timer and pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= ST_IDLE;
      mole       <= '0;
      score      <= '0;
      lives      <= LIVES_LOAD;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      timer      <= '0;
      prev_idx   <= '0;
      prev_vld   <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (st)
        ST_IDLE, ST_END: begin
          mole <= '0;
          if (start_rise) begin
            score <= '0;
            lives <= LIVES_LOAD;
            st    <= ST_SPAWN;
          end
        end
        ST_SPAWN: begin
          mole     <= NUM_HOLES'(onehot(MAX_IDX_W'(spawn_idx)));
          prev_idx <= spawn_idx;
          prev_vld <= 1'b1;
          timer    <= MOLE_LOAD;
          st       <= ST_UP;
        end
        ST_UP: begin
          if (wrong) begin
            // Wrong hole costs a life; the mole and its timer carry on
            lives      <= sat_dec(lives);
            miss_pulse <= 1'b1;
            timer      <= (timer == '0) ? timer : timer - TMR_W'(1);
            if (last_life) begin
              mole <= '0;
              st   <= ST_END;
            end
          end else if (correct) begin
            score     <= sat_inc(score);
            hit_pulse <= 1'b1;
            mole      <= '0;
            timer     <= GAP_LOAD;
            st        <= ST_GAP;
          end else if (timer == '0) begin
            lives      <= sat_dec(lives);
            miss_pulse <= 1'b1;
            mole       <= '0;
            timer      <= GAP_LOAD;
            st         <= last_life ? ST_END : ST_GAP;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        ST_GAP: begin
          mole <= '0;
          if (timer == '0) st <= ST_SPAWN;
          else             timer <= timer - TMR_W'(1);
        end
        default: begin
          mole <= '0;
          st   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_whack_a_mole_multi.sv
// Scoreboard bench for whack_a_mole_multi: stimulus pushes the expected
// hit/miss events, a monitor pops and checks them on each pulse.
module tb_whack_a_mole_multi;

  localparam int NH  = 4;
  localparam int SW  = 2;
  localparam int LW  = 4;
  localparam int LI  = 3;
  localparam int DEB = 4;
  localparam int MC  = 20;
  localparam int GC  = 5;

  localparam int S_IDLE = 0, S_SPAWN = 1, S_UP = 2, S_GAP = 3, S_END = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NH-1:0] buttons;
  logic [NH-1:0] mole;
  logic [SW-1:0] score;
  logic [LW-1:0] lives;
  logic [2:0]    state;
  logic          hit_pulse;
  logic          miss_pulse;

  typedef struct {
    bit            is_hit;
    int            sc;
    int            lv;
    int            st;
    logic [NH-1:0] ml;
  } ev_t;

  ev_t q[$];
  int  vecs = 0;
  int  errs = 0;
  int  cyc  = 0;

  whack_a_mole_multi #(
    .NUM_HOLES(NH), .SCORE_W(SW), .LIVES_W(LW), .LIVES_INIT(LI),
    .DEB_CYCLES(DEB), .MOLE_CYCLES(MC), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .buttons(buttons),
    .mole(mole), .score(score), .lives(lives), .state(state),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NH-1:0] oh(input int k);
    logic [NH-1:0] r;
    r    = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  function automatic void push(input bit h, input int sc, input int lv, input int st,
                               input logic [NH-1:0] ml);
    ev_t e;
    e.is_hit = h; e.sc = sc; e.lv = lv; e.st = st; e.ml = ml;
    q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_to_spawn", state, S_SPAWN);
  endtask

  task automatic wait_mole(output int k, output int t);
    bit found;
    found = 0;
    k = 0;
    t = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mole != '0) begin found = 1; break; end
    end
    chk("mole_appears", found, 1);
    if (found) begin
      chk("mole_onehot", $onehot(mole), 1);
      chk("mole_state_up", state, S_UP);
      for (int i = 0; i < NH; i++) if (mole[i]) k = i;
      t = cyc;
    end
  endtask

  task automatic wait_state(input int s, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (state == 3'(s)) break;
    end
    chk("reach_state", state, s);
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("events_drained", q.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state, S_IDLE);
    chk({tag, "_mole"},  mole, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_lives"}, lives, LI);
    chk({tag, "_hit"},   hit_pulse, 0);
    chk({tag, "_miss"},  miss_pulse, 0);
  endtask

  // Monitor: every hit/miss pulse must match the next expected event
  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && (hit_pulse === 1'b1 || miss_pulse === 1'b1)) begin
        if (q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL unexpected_event: hit=%0d miss=%0d score=%0d lives=%0d (cycle %0d)",
                   hit_pulse, miss_pulse, score, lives, cyc);
        end else begin
          e = q.pop_front();
          chk("ev_hit",   hit_pulse, e.is_hit);
          chk("ev_miss",  miss_pulse, !e.is_hit);
          chk("ev_score", score, e.sc);
          chk("ev_lives", lives, e.lv);
          chk("ev_state", state, e.st);
          chk("ev_mole",  mole, e.ml);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 40000", cyc);
    $fatal(1);
  end

  initial begin : stim
    int k, k2, j, t, t2, t0;
    bit seen;
    reset = 1'b1; start = 1'b0; buttons = '0;
    tick(3);
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1 reset = 1'b0;
    tick(2);
    chk_reset_vals("idle");

    // Hit: latency, pulse, then a different hole
    start_game();
    wait_mole(k, t);
    push(1, 1, 3, S_GAP, '0);
    @(posedge clk); #1 buttons[k] = 1'b1;
    t0 = cyc;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (score != 0) begin seen = 1; break; end
    end
    chk("hit_seen", seen, 1);
    chk("hit_latency", cyc - t0, DEB + 3);
    tick(3);
    buttons[k] = 1'b0;
    wait_mole(k2, t2);
    chk("new_hole_differs", (k2 != k), 1);

    // Bounce shorter than the debounce window
    @(posedge clk); #1 buttons[k2] = 1'b1;
    tick(2); buttons[k2] = 1'b0;
    tick(1); buttons[k2] = 1'b1;
    tick(2); buttons[k2] = 1'b0;
    tick(5);
    chk("bounce_mole", mole, oh(k2));
    chk("bounce_score", score, 1);
    chk("bounce_lives", lives, 3);

    // Wrong button, then timeout at the original time
    j = (k2 + 1) % NH;
    push(0, 1, 2, S_UP, oh(k2));
    push(0, 1, 1, S_GAP, '0);
    buttons[j] = 1'b1;
    tick(7);
    buttons[j] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mole == '0) break;
    end
    chk("timeout_time", cyc - t2, MC);

    // Game over and restart
    push(0, 1, 0, S_END, '0);
    wait_state(S_END, 100);
    tick(5);
    chk("end_hold_state", state, S_END);
    chk("end_mole", mole, 0);
    chk("end_score", score, 1);
    chk("end_lives", lives, 0);
    start_game();
    chk("restart_score", score, 0);
    chk("restart_lives", lives, LI);
    tick(1);
    chk("restart_up", state, S_UP);
    push(0, 0, 2, S_GAP, '0);
    push(0, 0, 1, S_GAP, '0);
    push(0, 0, 0, S_END, '0);
    wait_state(S_END, 300);
    wait_drain(20);

    // Saturation with a 2-bit score
    start_game();
    for (int n = 1; n <= 5; n++) begin
      wait_mole(k, t);
      push(1, (n > 3) ? 3 : n, 3, S_GAP, '0);
      @(posedge clk); #1 buttons[k] = 1'b1;
      tick(8);
      buttons[k] = 1'b0;
      wait_drain(20);
    end
    chk("sat_score", score, 3);

    // Correct and wrong button together count as a miss
    wait_mole(k, t);
    j = (k + 2) % NH;
    push(0, 3, 2, S_UP, oh(k));
    push(0, 3, 1, S_GAP, '0);
    @(posedge clk); #1 buttons[k] = 1'b1; buttons[j] = 1'b1;
    tick(7);
    buttons = '0;
    wait_drain(60);
    chk("collision_score", score, 3);

    // Asynchronous reset mid-UP with buttons held
    wait_mole(k, t);
    @(posedge clk); #1 buttons = '1;
    tick(2);
    #3 reset = 1'b1;
    #1 chk_reset_vals("async");
    tick(3);
    reset = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("post_reset_spawn", state, S_SPAWN);
    push(0, 0, 2, S_GAP, '0);
    tick(8);
    buttons = '0;
    wait_drain(60);
    wait_mole(k, t);
    push(1, 1, 2, S_GAP, '0);
    @(posedge clk); #1 buttons[k] = 1'b1;
    tick(8);
    buttons = '0;
    wait_drain(30);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/whack_a_mole_multi.md
Name: whack_a_mole_multi

Overview:
Parametrised successor to the single-button whack-a-mole game core. It drives NUM_HOLES moles, each with its own raw button input debounced internally. Mole placement comes from a free-running LFSR, and up-time and gap timers are programmable. It adds hit/miss pulses, score saturation and a wrong-button penalty. It sits between the board buttons/switches and the display/LED driver blocks.

Parameters:
NUM_HOLES, 4, number of moles/buttons; power of two, 2..16
SCORE_W, 8, score counter width
LIVES_W, 4, lives counter width
LIVES_INIT, 3, lives loaded at reset and at game start; 1..2^LIVES_W-1
DEB_CYCLES, 1000000, consecutive stable cycles required to accept a button level change
MOLE_CYCLES, 50000000, cycles a mole stays up before timeout
GAP_CYCLES, 10000000, blank cycles between moles

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  synchronous level; its rising edge starts or restarts a game from IDLE or END
buttons  in  NUM_HOLES  raw, asynchronous, bouncy buttons; bit i = hole i
mole  out  NUM_HOLES  one-hot visible mole, or all-zero
score  out  SCORE_W  hits this game
lives  out  LIVES_W  remaining lives
state  out  3  game state encoding
hit_pulse  out  1  one-cycle pulse on each scored hit
miss_pulse  out  1  one-cycle pulse on each life lost

Behaviour:
- Reset values: state=IDLE, mole=0, score=0, lives=LIVES_INIT, hit_pulse=0, miss_pulse=0, LFSR=16'hACE1, debouncer outputs=0, timers=0.
- All outputs are registered.
- Debounce, per channel:
  - 2-flop synchroniser feeds a stability counter.
  - The debounced level flips once the synced input has differed from it for DEB_CYCLES consecutive cycles. Any mismatch gap resets the counter.
  - A rising edge of the debounced level gives a 1-cycle press[i].
  - Raw step to press pulse: DEB_CYCLES+2 cycles.
- Score/lives/pulses update one cycle after press.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle including IDLE.
- State encoding: IDLE=0, SPAWN=1, UP=2, GAP=3, END=4.
- IDLE:
  - mole=0; all presses ignored.
  - start rising edge: score←0, lives←LIVES_INIT, go to SPAWN.
- SPAWN (1 cycle):
  - idx = LFSR[log2(NUM_HOLES)-1:0].
  - If idx equals the previous hole, use idx+1 modulo NUM_HOLES.
  - mole←onehot(idx), timer←MOLE_CYCLES-1, go to UP.
- UP, evaluated in this priority each cycle:
  1. Any press on a non-mole hole (even with a correct press in the same cycle): lives−1, miss_pulse. The mole stays up and the timer keeps running.
  2. Correct press only: score+1, saturating at 2^SCORE_W−1; hit_pulse; mole←0; timer←GAP_CYCLES-1; go to GAP.
  3. Timer==0 with no press: lives−1, miss_pulse, mole←0, go to GAP.
- GAP:
  - mole=0; presses ignored.
  - Timer==0: go to SPAWN.
- Lives reaching 0:
  - On any decrement that leaves lives=0: go to END, mole←0. This overrides GAP and SPAWN.
  - lives never wraps below 0.
- END:
  - score and lives held; mole=0.
  - start rising edge behaves as in IDLE.
- start edges seen in SPAWN/UP/GAP are ignored.
- Reset mid-game: everything returns to reset values immediately (asynchronous). A button held through reset yields no press until it has been released and re-pressed.

Decomposition:
- Package wam_pkg holds:
  - state encodings as named constants,
  - LFSR width, seed and tap constants,
  - a function mapping an index to one-hot.
- Sub-module wam_debouncer: one channel containing synchroniser, stability counter and rising-edge pulse, parametrised by DEB_CYCLES. Instantiated NUM_HOLES times in a generate loop.
- Top holds the FSM, LFSR, timers and counters.

Test Plan:
Bench parameters: DEB_CYCLES=4, MOLE_CYCLES=20, GAP_CYCLES=5, LIVES_INIT=3.
1. Hit: start edge, wait for mole=onehot(k), hold buttons[k] high 10 cycles. Required: score 0→1 exactly DEB_CYCLES+3 cycles after the raw edge, hit_pulse high 1 cycle, mole=0, state=GAP, then a new one-hot mole at a different hole.
2. Bounce: toggle buttons[k] high for 2 cycles, low for 1, high for 2, then low. Required: no press, score and lives unchanged, mole stays up.
3. Wrong button: press hole j≠k during UP. Required: lives 3→2, miss_pulse 1 cycle, mole still onehot(k), and timeout still fires at the original time.
4. Game over: no presses for three moles. Required: lives 3→2→1→0, state=END, mole=0. Then a start edge gives score=0, lives=3, state=SPAWN→UP.
5. Saturation and collision: with SCORE_W=2, score 5 hits. Required: score stays 3. Also press the correct and a wrong button in the same cycle. Required: counted as a miss, no score change.
6. Async reset: assert reset mid-UP with buttons held. Required: all outputs at reset values within the same cycle, and no press after release until the button is re-pressed.
